// File: rtl/arc4_encrypt_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : arc4_encrypt_if                                               |
// | Brief    : start handshake plus plaintext, ciphertext and S RAM ports    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface arc4_encrypt_if;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_rddata;
  logic [7:0]  ct_addr;
  logic [7:0]  ct_wrdata;
  logic        ct_wren;
  logic [7:0]  s_addr;
  logic [7:0]  s_rddata;
  logic [7:0]  s_wrdata;
  logic        s_wren;

  // master: the environment (requester and RAMs); slave: the engine
  modport master (
    output en, key, pt_rddata, s_rddata,
    input  rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, s_addr, s_wrdata, s_wren
  );

  modport slave (
    input  en, key, pt_rddata, s_rddata,
    output rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, s_addr, s_wrdata, s_wren
  );
endinterface
`default_nettype wire

// File: rtl/arc4_encrypt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : arc4_encrypt                                                  |
// | Brief    : RC4 encryption of a length-prefixed message, shared S RAM.    |
// |            Define ARC4_ENC_SCRUB_EN to zero S RAM before finishing.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module arc4_encrypt (
  input  wire logic     clk,
  input  wire logic     rst_n,
  arc4_encrypt_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT,
    S_K1, S_K2, S_K3, S_K4,
    S_L1, S_L2,
    S_P1, S_P2, S_P3, S_P4, S_P5, S_P6,
    S_SCRUB, S_DONE
  } state_t;

`ifdef ARC4_ENC_SCRUB_EN
  localparam state_t FINISH = S_SCRUB;
`else
  localparam state_t FINISH = S_DONE;
`endif

  state_t      state, state_d;
  logic [23:0] key_r, key_d;
  logic [7:0]  i, i_d;
  logic [7:0]  j, j_d;
  logic [7:0]  n, n_d;
  logic [1:0]  km, km_d;
  logic [8:0]  k, k_d;
  logic [7:0]  len, len_d;
  logic [7:0]  si, si_d;
  logic [7:0]  sj, sj_d;
  logic [7:0]  sn, sn_d;
  logic [7:0]  pt_b, pt_d;
  logic [7:0]  key_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      key_r <= '0;
      i     <= '0;
      j     <= '0;
      n     <= '0;
      km    <= '0;
      k     <= '0;
      len   <= '0;
      si    <= '0;
      sj    <= '0;
      sn    <= '0;
      pt_b  <= '0;
    end else begin
      state <= state_d;
      key_r <= key_d;
      i     <= i_d;
      j     <= j_d;
      n     <= n_d;
      km    <= km_d;
      k     <= k_d;
      len   <= len_d;
      si    <= si_d;
      sj    <= sj_d;
      sn    <= sn_d;
      pt_b  <= pt_d;
    end
  end

  // km tracks n mod 3 so no divider is needed
  always_comb begin
    case (km)
      2'd0:    key_byte = key_r[23:16];
      2'd1:    key_byte = key_r[15:8];
      default: key_byte = key_r[7:0];
    endcase
  end

  always_comb begin
    state_d       = state;
    key_d         = key_r;
    i_d           = i;
    j_d           = j;
    n_d           = n;
    km_d          = km;
    k_d           = k;
    len_d         = len;
    si_d          = si;
    sj_d          = sj;
    sn_d          = sn;
    pt_d          = pt_b;
    bus.rdy       = 1'b0;
    bus.pt_addr   = 8'd0;
    bus.ct_addr   = 8'd0;
    bus.ct_wrdata = 8'd0;
    bus.ct_wren   = 1'b0;
    bus.s_addr    = 8'd0;
    bus.s_wrdata  = 8'd0;
    bus.s_wren    = 1'b0;

    case (state)
      S_IDLE: begin
        bus.rdy = 1'b1;
        if (bus.en) begin
          key_d   = bus.key;
          i_d     = 8'd0;
          j_d     = 8'd0;
          n_d     = 8'd0;
          state_d = S_INIT;
        end
      end

      S_INIT: begin
        bus.s_addr   = n;
        bus.s_wrdata = n;
        bus.s_wren   = 1'b1;
        n_d          = n + 8'd1;
        if (n == 8'hFF) begin
          km_d    = 2'd0;
          j_d     = 8'd0;
          state_d = S_K1;
        end
      end

      S_K1: begin
        bus.s_addr = n;
        state_d    = S_K2;
      end

      S_K2: begin
        sn_d       = bus.s_rddata;
        j_d        = j + bus.s_rddata + key_byte;
        bus.s_addr = j_d;
        state_d    = S_K3;
      end

      S_K3: begin
        bus.s_addr   = n;
        bus.s_wrdata = bus.s_rddata;
        bus.s_wren   = 1'b1;
        state_d      = S_K4;
      end

      S_K4: begin
        bus.s_addr   = j;
        bus.s_wrdata = sn;
        bus.s_wren   = 1'b1;
        n_d          = n + 8'd1;
        km_d         = (km == 2'd2) ? 2'd0 : km + 2'd1;
        state_d      = (n == 8'hFF) ? S_L1 : S_K1;
      end

      S_L1: begin
        bus.pt_addr = 8'd0;
        state_d     = S_L2;
      end

      S_L2: begin
        bus.ct_addr   = 8'd0;
        bus.ct_wrdata = bus.pt_rddata;
        bus.ct_wren   = 1'b1;
        len_d         = bus.pt_rddata;
        i_d           = 8'd0;
        j_d           = 8'd0;
        n_d           = 8'd0;
        k_d           = 9'd1;
        state_d       = (bus.pt_rddata == 8'd0) ? FINISH : S_P1;
      end

      S_P1: begin
        i_d         = i + 8'd1;
        bus.s_addr  = i_d;
        bus.pt_addr = k[7:0];
        state_d     = S_P2;
      end

      S_P2: begin
        bus.pt_addr = k[7:0];
        si_d        = bus.s_rddata;
        pt_d        = bus.pt_rddata;
        j_d         = j + bus.s_rddata;
        bus.s_addr  = j_d;
        state_d     = S_P3;
      end

      S_P3: begin
        sj_d         = bus.s_rddata;
        bus.s_addr   = i;
        bus.s_wrdata = bus.s_rddata;
        bus.s_wren   = 1'b1;
        state_d      = S_P4;
      end

      S_P4: begin
        bus.s_addr   = j;
        bus.s_wrdata = si;
        bus.s_wren   = 1'b1;
        state_d      = S_P5;
      end

      S_P5: begin
        bus.s_addr = si + sj;
        state_d    = S_P6;
      end

      S_P6: begin
        bus.ct_addr   = k[7:0];
        bus.ct_wrdata = pt_b ^ bus.s_rddata;
        bus.ct_wren   = 1'b1;
        k_d           = k + 9'd1;
        state_d       = (k == {1'b0, len}) ? FINISH : S_P1;
      end

`ifdef ARC4_ENC_SCRUB_EN
      S_SCRUB: begin
        bus.s_addr   = n;
        bus.s_wrdata = 8'd0;
        bus.s_wren   = 1'b1;
        n_d          = n + 8'd1;
        if (n == 8'hFF) state_d = S_DONE;
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_arc4_encrypt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_arc4_encrypt                                               |
// | Brief    : scoreboard bench for arc4_encrypt with RAM models             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_arc4_encrypt;

`ifdef ARC4_ENC_SCRUB_EN
  localparam int SCRUB_CYC = 256;
`else
  localparam int SCRUB_CYC = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arc4_encrypt_if bus ();

  arc4_encrypt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [7:0]  pt_mem [256];
  logic [7:0]  ct_mem [256];
  logic [7:0]  s_mem  [256];
  logic [7:0]  model_s[256];
  logic [7:0]  orig   [256];
  logic [15:0] sb_q[$];
  logic [7:0]  std_ct [10];
  int n_checks = 0;
  int n_pass   = 0;
  int ct_writes = 0;
  int we_clash  = 0;

  always @(posedge clk) begin
    bus.s_rddata  <= s_mem[bus.s_addr];
    bus.pt_rddata <= pt_mem[bus.pt_addr];
    if (bus.s_wren)  s_mem[bus.s_addr]   <= bus.s_wrdata;
    if (bus.ct_wren) ct_mem[bus.ct_addr] <= bus.ct_wrdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (bus.s_wren && bus.ct_wren) we_clash++;
    if (bus.ct_wren) begin
      ct_writes++;
      if (sb_q.size() == 0) check("ct_unexpected", 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        check("ct_addr", {24'd0, bus.ct_addr}, {24'd0, e[15:8]});
        check("ct_data", {24'd0, bus.ct_wrdata}, {24'd0, e[7:0]});
      end
    end
  end

  // reference RC4 over the current plaintext RAM contents
  task automatic push_expected(input logic [23:0] key);
    logic [7:0] s[256];
    logic [7:0] kb[3];
    logic [7:0] i, j, t, pad, len;
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    for (int n = 0; n < 256; n++) s[n] = n[7:0];
    j = 8'd0;
    for (int n = 0; n < 256; n++) begin
      j = j + s[n] + kb[n % 3];
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    len = pt_mem[0];
    sb_q.push_back({8'h00, len});
    i = 8'd0;
    j = 8'd0;
    for (int kk = 1; kk <= int'(len); kk++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      t = s[i] + s[j];
      pad = s[t];
      sb_q.push_back({kk[7:0], pt_mem[kk] ^ pad});
    end
    for (int n = 0; n < 256; n++) model_s[n] = s[n];
  endtask

  task automatic start_op(input logic [23:0] key, input string tag);
    push_expected(key);
    @(negedge clk);
    bus.key = key;
    bus.en  = 1'b1;
    check({tag, "_rdy_idle"}, {31'd0, bus.rdy}, 32'd1);
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    check({tag, "_rdy_busy"}, {31'd0, bus.rdy}, 32'd0);
  endtask

  task automatic wait_done(input int exp_cyc, input string tag);
    int cyc = 1;
    while (!bus.rdy && cyc < 5000) begin
      @(posedge clk);
      #1;
      if (!bus.rdy) cyc++;
    end
    check({tag, "_busy_cycles"}, cyc, exp_cyc);
    check({tag, "_sb_empty"}, sb_q.size(), 0);
  endtask

  task automatic load_std();
    logic [7:0] msg[10];
    msg = '{8'h09, "P", "l", "a", "i", "n", "t", "e", "x", "t"};
    for (int n = 0; n < 10; n++) pt_mem[n] = msg[n];
  endtask

  task automatic check_std_ct(input string tag);
    for (int n = 0; n < 10; n++)
      check($sformatf("%s_ct%0d", tag, n), {24'd0, ct_mem[n]}, {24'd0, std_ct[n]});
  endtask

  initial begin
    int cw, mism;
    std_ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    bus.en  = 1'b0;
    bus.key = 24'd0;
    for (int n = 0; n < 256; n++) pt_mem[n] = 8'd0;

    #1;
    check("rst_rdy",     {31'd0, bus.rdy},     32'd1);
    check("rst_ct_wren", {31'd0, bus.ct_wren}, 32'd0);
    check("rst_s_wren",  {31'd0, bus.s_wren},  32'd0);
    check("rst_s_addr",  {24'd0, bus.s_addr},  32'd0);
    check("rst_pt_addr", {24'd0, bus.pt_addr}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // standard vector, with final S state
    load_std();
    start_op(24'h4B6579, "std");
    wait_done(1337 + SCRUB_CYC, "std");
    check_std_ct("std");
    mism = 0;
    for (int n = 0; n < 256; n++)
      if (s_mem[n] !== ((SCRUB_CYC != 0) ? 8'd0 : model_s[n])) mism++;
    check("std_s_final", mism, 0);

    // empty message
    pt_mem[0] = 8'd0;
    cw = ct_writes;
    start_op(24'h4B6579, "len0");
    wait_done(1283 + SCRUB_CYC, "len0");
    check("len0_ct_writes", ct_writes - cw, 1);
    check("len0_ct0", {24'd0, ct_mem[0]}, 32'd0);

    // en pulse and key change during KSA must be ignored
    load_std();
    start_op(24'h4B6579, "busy");
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (c == 270) begin bus.key = 24'hFFFFFF; bus.en = 1'b1; end
      if (c == 280) bus.en = 1'b0;
    end
    check("busy_rdy_low", {31'd0, bus.rdy}, 32'd0);
    wait_done(1337 + SCRUB_CYC - 300, "busy");
    check_std_ct("busy");

    // round trip with a 53-byte message
    pt_mem[0] = 8'd53;
    for (int n = 1; n <= 53; n++) pt_mem[n] = 8'($urandom);
    for (int n = 0; n <= 53; n++) orig[n] = pt_mem[n];
    start_op(24'h000001, "rt1");
    wait_done(1283 + 6 * 53 + SCRUB_CYC, "rt1");
    for (int n = 0; n <= 53; n++) pt_mem[n] = ct_mem[n];
    start_op(24'h000001, "rt2");
    wait_done(1283 + 6 * 53 + SCRUB_CYC, "rt2");
    mism = 0;
    for (int n = 0; n <= 53; n++) if (ct_mem[n] !== orig[n]) mism++;
    check("rt_restored", mism, 0);

    // asynchronous reset during PRGA byte 4
    load_std();
    cw = ct_writes;
    start_op(24'h4B6579, "rst");
    for (int c = 0; c < 3000 && ct_writes < cw + 4; c++) begin
      @(posedge clk);
      #1;
    end
    check("rst_reached_byte4", ct_writes - cw, 4);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdy",     {31'd0, bus.rdy},     32'd1);
    check("mid_rst_ct_wren", {31'd0, bus.ct_wren}, 32'd0);
    check("mid_rst_s_wren",  {31'd0, bus.s_wren},  32'd0);
    sb_q.delete();
    cw = ct_writes;
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst_no_writes", ct_writes - cw, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(24'h4B6579, "fresh");
    wait_done(1337 + SCRUB_CYC, "fresh");
    check_std_ct("fresh");

    check("we_exclusive", we_clash, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
